// File: rtl/uart_loop_bist.sv
// Multi-lane UART loopback self-test: LFSR frames out on o_tx, checked back on i_rx.
// Optional even-parity bit per frame when UART_BIST_PARITY_EN is defined.
module uart_loop_bist #(
    parameter int CHANNELS   = 4,
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rstn,
    input  logic                          i_start,
    input  logic                          i_stop,
    input  logic [DIV_WIDTH-1:0]          i_div,
    input  logic [CNT_WIDTH-1:0]          i_frames,
    input  logic [DATA_BITS-1:0]          i_seed,
    output logic [CHANNELS-1:0]           o_tx,
    input  logic [CHANNELS-1:0]           i_rx,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_pass,
    output logic [CNT_WIDTH-1:0]          o_frame_cnt,
    output logic [CHANNELS*CNT_WIDTH-1:0] o_err_cnt
);

`ifdef UART_BIST_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME_BITS = DATA_BITS + 2 + PAR_BITS;
    localparam int BW = $clog2(FRAME_BITS);
    localparam int OW = $clog2(OVERSAMPLE);
    localparam int TO_TICKS = 2 * FRAME_BITS * OVERSAMPLE;
    localparam int TW = $clog2(TO_TICKS);
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);
    localparam logic [BW-1:0] STOP_RX = BW'(FRAME_BITS - 2);
    localparam logic [OW-1:0] OS_LAST = OW'(OVERSAMPLE - 1);
    localparam logic [OW-1:0] OS_HALF = OW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TO_TICKS - 1);
    localparam logic [8:0] TAPS9 =
        (DATA_BITS == 5) ? 9'h014 :
        (DATA_BITS == 6) ? 9'h030 :
        (DATA_BITS == 7) ? 9'h060 :
        (DATA_BITS == 8) ? 9'h0B8 : 9'h110;
    localparam logic [DATA_BITS-1:0] TAPS = TAPS9[DATA_BITS-1:0];

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    function automatic logic [DATA_BITS-1:0] lfsr_step(input logic [DATA_BITS-1:0] v);
        return (v >> 1) ^ (v[0] ? TAPS : '0);
    endfunction

    function automatic logic [DATA_BITS-1:0] lane_seed(input logic [DATA_BITS-1:0] s,
                                                       input int k);
        logic [DATA_BITS-1:0] v;
        v = s ^ DATA_BITS'(k);
        return (v == '0) ? DATA_BITS'(1) : v;
    endfunction

    // Line level for frame bit idx: start, data LSB first, [parity], stop.
    function automatic logic tx_val(input logic [DATA_BITS-1:0] d,
                                    input logic [BW-1:0] idx);
        logic b;
        b = 1'b1;
        if (idx == '0) b = 1'b0;
        for (int i = 0; i < DATA_BITS; i++)
            if (idx == BW'(i + 1)) b = d[i];
`ifdef UART_BIST_PARITY_EN
        if (idx == BW'(DATA_BITS + 1)) b = ^d;
`endif
        return b;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [CNT_WIDTH-1:0] b);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
    endfunction

    state_t state, state_nxt;

    logic [DIV_WIDTH-1:0] div_r, div_cnt;
    logic [CNT_WIDTH-1:0] frames_r, frame_cnt;
    logic                 tx_on, stop_req;
    logic [OW-1:0]        tx_os;
    logic [BW-1:0]        tx_bit;
    logic [TW-1:0]        to_cnt;
    logic [DATA_BITS-1:0] tx_data [CHANNELS];

    logic [CHANNELS-1:0]  rx_m, rx_s, rx_prev, rx_act, rx_chk;
    logic [OW-1:0]        rx_os  [CHANNELS];
    logic [BW-1:0]        rx_bit [CHANNELS];
    logic [DATA_BITS-1:0] rx_sh  [CHANNELS];
    logic [DATA_BITS-1:0] rx_exp [CHANNELS];
    logic [CNT_WIDTH-1:0] rx_cnt [CHANNELS];
    logic [CNT_WIDTH-1:0] err    [CHANNELS];
`ifdef UART_BIST_PARITY_EN
    logic [CHANNELS-1:0]  rx_par;
`endif

    logic go, tick, frame_end, last_frame, timeout, drain_to, rx_quiet, err_any;

    assign o_busy      = (state == RUN) || (state == DRAIN);
    assign o_done      = (state == DONE);
    assign o_frame_cnt = frame_cnt;
    assign go          = (state == IDLE) && i_start;
    assign tick        = o_busy && (div_cnt == div_r);
    assign frame_end   = (state == RUN) && tick && tx_on &&
                         (tx_os == OS_LAST) && (tx_bit == LAST_BIT);
    assign last_frame  = stop_req || i_stop ||
                         ((frames_r != '0) && (frame_cnt + CNT_WIDTH'(1) == frames_r));
    assign timeout     = tick && (to_cnt == TO_LAST);
    assign drain_to    = (state == DRAIN) && timeout;

    always_comb begin
        rx_quiet  = 1'b1;
        err_any   = 1'b0;
        o_err_cnt = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (rx_act[k] || (rx_cnt[k] != frame_cnt)) rx_quiet = 1'b0;
            if (err[k] != '0) err_any = 1'b1;
            o_err_cnt[k*CNT_WIDTH +: CNT_WIDTH] = err[k];
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (i_start) state_nxt = RUN;
            RUN:   if (frame_end && last_frame) state_nxt = DRAIN;
            DRAIN: if (rx_quiet || timeout) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            div_r     <= '0;
            div_cnt   <= '0;
            frames_r  <= '0;
            frame_cnt <= '0;
            tx_on     <= 1'b0;
            stop_req  <= 1'b0;
            tx_os     <= '0;
            tx_bit    <= '0;
            to_cnt    <= '0;
            o_pass    <= 1'b0;
            o_tx      <= '1;
            for (int k = 0; k < CHANNELS; k++) tx_data[k] <= '0;
        end else if (go) begin
            div_r     <= i_div;
            div_cnt   <= '0;
            frames_r  <= i_frames;
            frame_cnt <= '0;
            tx_on     <= 1'b0;
            stop_req  <= 1'b0;
            tx_os     <= '0;
            tx_bit    <= '0;
            to_cnt    <= '0;
            o_pass    <= 1'b0;
            o_tx      <= '1;
            for (int k = 0; k < CHANNELS; k++) tx_data[k] <= lane_seed(i_seed, k);
        end else begin
            if (o_busy) div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if ((state == RUN) && i_stop) stop_req <= 1'b1;
            if ((state == DRAIN) && tick) to_cnt <= to_cnt + 1'b1;
            if (state == DONE) o_pass <= !err_any;
            if ((state == RUN) && tick) begin
                if (!tx_on) begin
                    tx_on  <= 1'b1;
                    tx_os  <= '0;
                    tx_bit <= '0;
                    o_tx   <= '0;
                end else if (tx_os != OS_LAST) begin
                    tx_os <= tx_os + 1'b1;
                end else begin
                    tx_os <= '0;
                    if (tx_bit == LAST_BIT) begin
                        frame_cnt <= frame_cnt + 1'b1;
                        for (int k = 0; k < CHANNELS; k++)
                            tx_data[k] <= lfsr_step(tx_data[k]);
                        tx_bit <= '0;
                        // Back-to-back frames: the next start bit follows the stop bit directly.
                        if (last_frame) begin
                            tx_on <= 1'b0;
                            o_tx  <= '1;
                        end else begin
                            o_tx <= '0;
                        end
                    end else begin
                        tx_bit <= tx_bit + 1'b1;
                        for (int k = 0; k < CHANNELS; k++)
                            o_tx[k] <= tx_val(tx_data[k], tx_bit + 1'b1);
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rx_m    <= '1;
            rx_s    <= '1;
            rx_prev <= '1;
            rx_act  <= '0;
            rx_chk  <= '0;
`ifdef UART_BIST_PARITY_EN
            rx_par  <= '0;
`endif
            for (int k = 0; k < CHANNELS; k++) begin
                rx_os[k]  <= '0;
                rx_bit[k] <= '0;
                rx_sh[k]  <= '0;
                rx_exp[k] <= '0;
                rx_cnt[k] <= '0;
                err[k]    <= '0;
            end
        end else begin
            rx_m <= i_rx;
            rx_s <= rx_m;
            for (int k = 0; k < CHANNELS; k++) begin
                if (go) begin
                    rx_prev[k] <= 1'b1;
                    rx_act[k]  <= 1'b0;
                    rx_chk[k]  <= 1'b0;
                    rx_exp[k]  <= lane_seed(i_seed, k);
                    rx_cnt[k]  <= '0;
                    err[k]     <= '0;
                end else if (drain_to) begin
                    err[k] <= sat_add(err[k], frame_cnt - rx_cnt[k]);
                end else if (tick) begin
                    rx_prev[k] <= rx_s[k];
                    if (!rx_act[k]) begin
                        if (rx_prev[k] && !rx_s[k]) begin
                            rx_act[k] <= 1'b1;
                            rx_chk[k] <= 1'b1;
                            rx_os[k]  <= '0;
                            rx_bit[k] <= '0;
                        end
                    end else if (rx_chk[k]) begin
                        // Mid start bit: a high line means the edge was a glitch.
                        if (rx_os[k] == OS_HALF) begin
                            rx_chk[k] <= 1'b0;
                            rx_os[k]  <= '0;
                            if (rx_s[k]) rx_act[k] <= 1'b0;
                        end else begin
                            rx_os[k] <= rx_os[k] + 1'b1;
                        end
                    end else if (rx_os[k] != OS_LAST) begin
                        rx_os[k] <= rx_os[k] + 1'b1;
                    end else begin
                        rx_os[k] <= '0;
                        if (rx_bit[k] == STOP_RX) begin
                            rx_act[k] <= 1'b0;
                            rx_cnt[k] <= rx_cnt[k] + 1'b1;
                            rx_exp[k] <= lfsr_step(rx_exp[k]);
                            if ((rx_sh[k] != rx_exp[k]) || !rx_s[k]
`ifdef UART_BIST_PARITY_EN
                                || (rx_par[k] != ^rx_sh[k])
`endif
                               )
                                err[k] <= sat_add(err[k], CNT_WIDTH'(1));
                        end else begin
                            rx_bit[k] <= rx_bit[k] + 1'b1;
                            if (rx_bit[k] < BW'(DATA_BITS))
                                rx_sh[k] <= {rx_s[k], rx_sh[k][DATA_BITS-1:1]};
`ifdef UART_BIST_PARITY_EN
                            else
                                rx_par[k] <= rx_s[k];
`endif
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_loop_bist.sv
// Directed bench for uart_loop_bist: ring loopback, injected faults, drain timeout, stop, reset.
module tb_uart_loop_bist;

`ifdef UART_BIST_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stop;
    logic [15:0] div, frames;
    logic [7:0]  seed;
    logic [3:0]  tx, rx;
    logic        busy, done, pass;
    logic [15:0] frame_cnt;
    logic [63:0] err_cnt;
    logic [3:0]  inv_mask = '0;
    logic [3:0]  hi_mask = '0;
    logic [7:0]  cap [4];
    int          checks = 0;
    int          failures = 0;

    assign rx = (tx ^ inv_mask) | hi_mask;

    always #5 clk = ~clk;

    uart_loop_bist dut (
        .i_clk(clk), .i_rstn(rst_n), .i_start(start), .i_stop(stop),
        .i_div(div), .i_frames(frames), .i_seed(seed), .o_tx(tx), .i_rx(rx),
        .o_busy(busy), .o_done(done), .o_pass(pass),
        .o_frame_cnt(frame_cnt), .o_err_cnt(err_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_cnt(input logic [15:0] n, input int limit, input string tag);
        int c;
        c = 0;
        while (frame_cnt !== n && c < limit) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk(tag, 64'(frame_cnt === n), 64'd1);
    endtask

    task automatic wait_done(input int limit, input string tag, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (done !== 1'b1 && cyc < limit);
        chk(tag, 64'(done), 64'd1);
    endtask

    initial begin
        int cyc;
        int t;
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        div = 16'd0;
        frames = 16'd10;
        seed = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", 64'(tx), 64'hF);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_pass", 64'(pass), 64'd0);
        chk("rst_fcnt", 64'(frame_cnt), 64'd0);
        chk("rst_err", err_cnt, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Ring, 10 frames; also checks frame length and start-while-busy.
        pulse_start();
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (frame_cnt !== 16'd1 && cyc < 1000);
        chk("frame_len", 64'(cyc), 64'(1 + FB * 16));
        chk("busy_run", 64'(busy), 64'd1);
        pulse_start();
        wait_done(4000, "t1_done", cyc);
        chk("t1_fcnt", 64'(frame_cnt), 64'd10);
        chk("t1_err", err_cnt, 64'd0);
        @(posedge clk);
        #1;
        chk("t1_pass", 64'(pass), 64'd1);
        chk("t1_done_pulse", 64'(done), 64'd0);

        // ch2 data bit 3 of frame 4 inverted on the return path.
        frames = 16'd6;
        seed = 8'h3C;
        pulse_start();
        wait_cnt(16'd4, 2000, "t2_wait4");
        repeat (66) @(posedge clk);
        inv_mask = 4'b0100;
        repeat (12) @(posedge clk);
        inv_mask = 4'b0000;
        wait_done(3000, "t2_done", cyc);
        chk("t2_err", err_cnt, 64'h0000_0001_0000_0000);
        @(posedge clk);
        #1;
        chk("t2_pass", 64'(pass), 64'd0);

        // ch1 rx stuck high: drain timeout, missing frames become errors.
        hi_mask = 4'b0010;
        frames = 16'd5;
        seed = 8'h00;
        pulse_start();
        wait_cnt(16'd5, 1500, "t3_wait5");
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (done !== 1'b1 && cyc < 1000);
        chk("t3_timeout", 64'(cyc), 64'(2 * FB * 16));
        chk("t3_err", err_cnt, 64'h0000_0000_0005_0000);
        @(posedge clk);
        #1;
        chk("t3_pass", 64'(pass), 64'd0);
        hi_mask = 4'b0000;

        // Continuous mode, start and stop together (start wins), stop mid frame 7.
        frames = 16'd0;
        div = 16'd3;
        seed = 8'h5A;
        @(negedge clk);
        start = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        div = 16'd0;
        frames = 16'd2;
        wait_cnt(16'd6, 5000, "t4_wait6");
        chk("t4_busy", 64'(busy), 64'd1);
        repeat (200) @(posedge clk);
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_done(2000, "t4_done", cyc);
        chk("t4_fcnt", 64'(frame_cnt), 64'd7);
        @(posedge clk);
        #1;
        chk("t4_pass", 64'(pass), 64'd1);

        // Reset mid frame, then rerun and capture the first frames.
        div = 16'd0;
        frames = 16'd3;
        seed = 8'hA5;
        pulse_start();
        wait_cnt(16'd2, 1000, "t5_wait2");
        repeat (50) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_tx", 64'(tx), 64'hF);
        chk("t5_rst_busy", 64'(busy), 64'd0);
        #10;
        rst_n = 1'b1;
        pulse_start();
        t = 0;
        repeat (9 - t) @(posedge clk);
        t = 9;
        #1;
        chk("t5_start_bit", 64'(tx), 64'h0);
        for (int b = 1; b <= 8; b++) begin
            n = 9 + 16 * b;
            repeat (n - t) @(posedge clk);
            t = n;
            #1;
            for (int k = 0; k < 4; k++) cap[k][b-1] = tx[k];
        end
        chk("t5_f0_ch0", 64'(cap[0]), 64'hA5);
        chk("t5_f0_ch1", 64'(cap[1]), 64'hA4);
        chk("t5_f0_ch3", 64'(cap[3]), 64'hA6);
        for (int b = 1; b <= 8; b++) begin
            n = 9 + FB * 16 + 16 * b;
            repeat (n - t) @(posedge clk);
            t = n;
            #1;
            cap[0][b-1] = tx[0];
        end
        chk("t5_f1_ch0", 64'(cap[0]), 64'hEA);
        wait_done(2000, "t5_done", cyc);
        @(posedge clk);
        #1;
        chk("t5_pass", 64'(pass), 64'd1);

`ifdef UART_BIST_PARITY_EN
        // ch0 parity bit of frame 2 flipped on the return path.
        frames = 16'd4;
        seed = 8'h11;
        pulse_start();
        wait_cnt(16'd2, 1000, "t6_wait2");
        repeat (146) @(posedge clk);
        inv_mask = 4'b0001;
        repeat (12) @(posedge clk);
        inv_mask = 4'b0000;
        wait_done(2000, "t6_done", cyc);
        chk("t6_err", err_cnt, 64'h0000_0000_0000_0001);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
